// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I/RV64I decode stage:
//   - major opcode constants
//   - instruction format code (itype_e) as presented on out_itype
//   - funct7 constants for OP / OP-32
//   - the per-instruction field bundle held in the pipeline registers
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        ITYPE_R    = 3'd0,
        ITYPE_I    = 3'd1,
        ITYPE_S    = 3'd2,
        ITYPE_B    = 3'd3,
        ITYPE_U    = 3'd4,
        ITYPE_J    = 3'd5,
        ITYPE_NONE = 3'd7
    } itype_e;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;  // SUB / SRA
    localparam logic [6:0] F7_MULDIV = 7'h01;  // M extension

    // Everything about a decoded instruction except the XLEN-wide pc/imm,
    // which live beside it because a package cannot be parameterised.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        itype_e     itype;
        logic       illegal;
    } dec_fields_t;

    localparam dec_fields_t DEC_FIELDS_RESET = '{
        opcode:  7'd0,
        funct3:  3'd0,
        funct7:  7'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        itype:   ITYPE_NONE,
        illegal: 1'b0
    };

    // Register-register ops: base funct7, SUB/SRA only on funct3 0/5,
    // and the MUL/DIV family only when that extension is enabled.
    function automatic logic op_funct7_legal(input logic [6:0] funct7,
                                             input logic [2:0] funct3,
                                             input logic       mext_en);
        return (funct7 == F7_BASE) ||
               ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))) ||
               (mext_en && (funct7 == F7_MULDIV));
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator. Reassembles the I/S/B/U/J immediate
// from the instruction word and sign-extends it to XLEN. R-type and NONE
// produce zero.
// Ports:
//   inst  [31:7]     instruction word without the opcode (never part of an imm)
//   itype            format code selecting the bit scramble
//   imm   [XLEN-1:0] sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  itype_e          itype,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (itype)
            ITYPE_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            ITYPE_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ITYPE_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                              inst[11:8], 1'b0};
            ITYPE_U: imm32 = {inst[31:12], 12'h000};
            ITYPE_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm[31:0] = imm32;

    // Upper half (RV64 only) replicates the 32-bit sign; empty when XLEN=32.
    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_sext
            assign imm[gi] = imm32[31];
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered RV32I/RV64I decode stage between fetch and execute. Decodes the
// incoming word combinationally, captures it into the main register (M) or,
// when M is stalled, into a skid register (S). All outputs come from M.
// in_ready is simply !S.valid, so it never depends on out_ready in the same
// cycle.
//
// Optional feature macro: DECODE_MEXT_EN -- when defined, OP / OP-32 with
// funct7=0x01 (MUL/DIV/REM) decode as legal R-type; otherwise illegal.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   drop M, S and any same-cycle input
//   in_valid/in_ready       fetch handshake; in_inst, in_pc payload
//   out_valid/out_ready     execute handshake
//   out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
//   out_imm, out_itype, out_illegal   decoded instruction from M
// -----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_itype,
    output logic            out_illegal
);

`ifdef DECODE_MEXT_EN
    localparam logic MEXT_EN = 1'b1;
`else
    localparam logic MEXT_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- decode
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_shift;
    logic [6:0]      shift_hi;
    logic            legal;
    itype_e          fmt;
    dec_fields_t     dec_fields;
    logic [XLEN-1:0] dec_imm;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    // funct3 1 (SLLI) and 5 (SRLI/SRAI) are the shift-immediate forms.
    assign is_shift = (funct3[1:0] == 2'b01);
    // Bits above a 5-bit shamt; bit 30 selects SRAI for right shifts so it
    // is masked there. RV64 uses a 6-bit shamt and ignores shift_hi[0].
    assign shift_hi = {in_inst[31], in_inst[30] & ~funct3[2], in_inst[29:25]};

    always_comb begin
        fmt   = ITYPE_NONE;
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt   = ITYPE_U;
                legal = 1'b1;
            end
            OPC_JAL: begin
                fmt   = ITYPE_J;
                legal = 1'b1;
            end
            OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt   = ITYPE_I;
                legal = 1'b1;
            end
            OPC_BRANCH: begin
                fmt   = ITYPE_B;
                legal = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                fmt   = ITYPE_I;
                // LD (3) and LWU (6) exist only on RV64; 7 never.
                legal = (funct3 != 3'd7) &&
                        ((XLEN == 64) || ((funct3 != 3'd3) && (funct3 != 3'd6)));
            end
            OPC_STORE: begin
                fmt   = ITYPE_S;
                legal = !funct3[2] && ((XLEN == 64) || (funct3 != 3'd3));
            end
            OPC_OP_IMM: begin
                fmt = ITYPE_I;
                if (XLEN == 64) begin
                    legal = !is_shift || (shift_hi[6:1] == 6'd0);
                end else begin
                    legal = !is_shift || (shift_hi == 7'd0);
                end
            end
            OPC_OP: begin
                fmt   = ITYPE_R;
                legal = op_funct7_legal(funct7, funct3, MEXT_EN);
            end
            OPC_OP_IMM_32: begin
                // Word shifts always have a 5-bit shamt.
                fmt   = ITYPE_I;
                legal = (XLEN == 64) && (!is_shift || (shift_hi == 7'd0));
            end
            OPC_OP_32: begin
                fmt   = ITYPE_R;
                legal = (XLEN == 64) && op_funct7_legal(funct7, funct3, MEXT_EN);
            end
            default: begin
                fmt   = ITYPE_NONE;
                legal = 1'b0;
            end
        endcase
        if ((in_inst[1:0] != 2'b11) || !legal) begin
            fmt = ITYPE_NONE;
        end
    end

    always_comb begin
        dec_fields         = DEC_FIELDS_RESET;
        dec_fields.opcode  = opcode;
        dec_fields.funct3  = funct3;
        dec_fields.funct7  = funct7;
        dec_fields.itype   = fmt;
        dec_fields.illegal = (fmt == ITYPE_NONE);
        case (fmt)
            ITYPE_R: begin
                dec_fields.rs1 = in_inst[19:15];
                dec_fields.rs2 = in_inst[24:20];
                dec_fields.rd  = in_inst[11:7];
            end
            ITYPE_I: begin
                dec_fields.rs1 = in_inst[19:15];
                dec_fields.rd  = in_inst[11:7];
            end
            ITYPE_S, ITYPE_B: begin
                dec_fields.rs1 = in_inst[19:15];
                dec_fields.rs2 = in_inst[24:20];
            end
            ITYPE_U, ITYPE_J: begin
                dec_fields.rd  = in_inst[11:7];
            end
            default: ;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (in_inst[31:7]),
        .itype (fmt),
        .imm   (dec_imm)
    );

    // ------------------------------------------------------- M / S pipeline
    logic            m_valid_reg, m_valid_next;
    logic            s_valid_reg, s_valid_next;
    dec_fields_t     m_dec_reg, m_dec_next;
    dec_fields_t     s_dec_reg, s_dec_next;
    logic [XLEN-1:0] m_pc_reg, m_pc_next, m_imm_reg, m_imm_next;
    logic [XLEN-1:0] s_pc_reg, s_pc_next, s_imm_reg, s_imm_next;
    logic            in_xfer;
    logic            m_free;

    assign in_xfer = in_valid && !s_valid_reg;
    // M may take new content when it is empty or its content leaves now.
    assign m_free  = !m_valid_reg || out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_dec_next   = m_dec_reg;
        m_pc_next    = m_pc_reg;
        m_imm_next   = m_imm_reg;
        s_valid_next = s_valid_reg;
        s_dec_next   = s_dec_reg;
        s_pc_next    = s_pc_reg;
        s_imm_next   = s_imm_reg;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (m_free) begin
            if (s_valid_reg) begin
                // S holds the older instruction; no input can arrive while
                // S is full, so FIFO order is preserved.
                m_valid_next = 1'b1;
                m_dec_next   = s_dec_reg;
                m_pc_next    = s_pc_reg;
                m_imm_next   = s_imm_reg;
                s_valid_next = 1'b0;
            end else if (in_xfer) begin
                m_valid_next = 1'b1;
                m_dec_next   = dec_fields;
                m_pc_next    = in_pc;
                m_imm_next   = dec_imm;
            end else begin
                m_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            s_valid_next = 1'b1;
            s_dec_next   = dec_fields;
            s_pc_next    = in_pc;
            s_imm_next   = dec_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_dec_reg   <= DEC_FIELDS_RESET;
            m_pc_reg    <= '0;
            m_imm_reg   <= '0;
            s_valid_reg <= 1'b0;
            s_dec_reg   <= DEC_FIELDS_RESET;
            s_pc_reg    <= '0;
            s_imm_reg   <= '0;
        end else begin
            m_valid_reg <= m_valid_next;
            m_dec_reg   <= m_dec_next;
            m_pc_reg    <= m_pc_next;
            m_imm_reg   <= m_imm_next;
            s_valid_reg <= s_valid_next;
            s_dec_reg   <= s_dec_next;
            s_pc_reg    <= s_pc_next;
            s_imm_reg   <= s_imm_next;
        end
    end

    // -------------------------------------------------------------- outputs
    assign in_ready    = !s_valid_reg;
    assign out_valid   = m_valid_reg;
    assign out_pc      = m_pc_reg;
    assign out_opcode  = m_dec_reg.opcode;
    assign out_funct3  = m_dec_reg.funct3;
    assign out_funct7  = m_dec_reg.funct7;
    assign out_rs1     = m_dec_reg.rs1;
    assign out_rs2     = m_dec_reg.rs2;
    assign out_rd      = m_dec_reg.rd;
    assign out_imm     = m_imm_reg;
    assign out_itype   = m_dec_reg.itype;
    assign out_illegal = m_dec_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Drives an XLEN=32 and an XLEN=64 decode_stage with identical stimulus.
// A reference model (queue of accepted instructions + rule-based decoder)
// predicts every output; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_decode_stage;

`ifdef DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        o32_in_ready, o32_valid, o32_illegal;
    logic [31:0] o32_pc, o32_imm;
    logic [6:0]  o32_opcode, o32_funct7;
    logic [2:0]  o32_funct3, o32_itype;
    logic [4:0]  o32_rs1, o32_rs2, o32_rd;

    logic        o64_in_ready, o64_valid, o64_illegal;
    logic [63:0] o64_pc, o64_imm;
    logic [6:0]  o64_opcode, o64_funct7;
    logic [2:0]  o64_funct3, o64_itype;
    logic [4:0]  o64_rs1, o64_rs2, o64_rd;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o32_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(o32_valid), .out_ready(out_ready),
        .out_pc(o32_pc), .out_opcode(o32_opcode), .out_funct3(o32_funct3),
        .out_funct7(o32_funct7), .out_rs1(o32_rs1), .out_rs2(o32_rs2),
        .out_rd(o32_rd), .out_imm(o32_imm), .out_itype(o32_itype),
        .out_illegal(o32_illegal)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o64_in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(o64_valid), .out_ready(out_ready),
        .out_pc(o64_pc), .out_opcode(o64_opcode), .out_funct3(o64_funct3),
        .out_funct7(o64_funct7), .out_rs1(o64_rs1), .out_rs2(o64_rs2),
        .out_rd(o64_rd), .out_imm(o64_imm), .out_itype(o64_itype),
        .out_illegal(o64_illegal)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  itype;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    item_t q[$];

    function automatic bit shamt_ok(input logic [31:0] w, input logic [2:0] f3, input int sw);
        logic [11:0] upper;
        upper = w[31:20] >> sw;
        if (f3 == 3'd5) upper[10 - sw] = 1'b0;   // bit 30: arithmetic shift
        return upper == 12'd0;
    endfunction

    function automatic bit r_ok(input logic [6:0] f7, input logic [2:0] f3, input bit mext);
        return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
               (mext && f7 == 7'h01);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input int xlen, input bit mext);
        exp_t e;
        int fmt;
        bit ok;
        logic [2:0] f3;
        logic [6:0] f7;
        longint v;
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        fmt = 7;
        case (w[6:0])
            7'h37, 7'h17: fmt = 4;
            7'h6F:        fmt = 5;
            7'h67, 7'h0F, 7'h73: fmt = 1;
            7'h63: begin fmt = 3; ok = (f3 != 3'd2 && f3 != 3'd3); end
            7'h03: begin
                fmt = 1;
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ||
                     (xlen == 64 && (f3 == 3 || f3 == 6));
            end
            7'h23: begin fmt = 2; ok = (f3 <= 3'd2) || (xlen == 64 && f3 == 3'd3); end
            7'h13: begin
                fmt = 1;
                if (f3 == 3'd1 || f3 == 3'd5) ok = shamt_ok(w, f3, (xlen == 64) ? 6 : 5);
            end
            7'h1B: begin
                fmt = 1;
                ok = (xlen == 64) && (!(f3 == 3'd1 || f3 == 3'd5) || shamt_ok(w, f3, 5));
            end
            7'h33: begin fmt = 0; ok = r_ok(f7, f3, mext); end
            7'h3B: begin fmt = 0; ok = (xlen == 64) && r_ok(f7, f3, mext); end
            default: ok = 1'b0;
        endcase
        if (w[1:0] != 2'b11) ok = 1'b0;
        if (!ok) fmt = 7;
        case (fmt)
            1: v = $signed(w[31:20]);
            2: v = $signed({w[31:25], w[11:7]});
            3: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            4: v = $signed({w[31:12], 12'h000});
            5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: v = 0;
        endcase
        e.opcode  = w[6:0];
        e.funct3  = f3;
        e.funct7  = f7;
        e.rs1     = (fmt <= 3) ? w[19:15] : 5'd0;
        e.rs2     = (fmt == 0 || fmt == 2 || fmt == 3) ? w[24:20] : 5'd0;
        e.rd      = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) ? w[11:7] : 5'd0;
        e.imm     = v;
        e.itype   = 3'(fmt);
        e.illegal = !ok;
        return e;
    endfunction

    // Model: at most two instructions buffered; head is presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit pop, push;
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{inst: in_inst, pc: in_pc});
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e32, e64;
        if (!rst_n) begin
            chk("rst_out_valid32", o32_valid, 0);
            chk("rst_in_ready32", o32_in_ready, 1);
            chk("rst_out_valid64", o64_valid, 0);
        end else begin
            chk("in_ready32", o32_in_ready, q.size() < 2);
            chk("in_ready64", o64_in_ready, q.size() < 2);
            chk("out_valid32", o32_valid, q.size() > 0);
            chk("out_valid64", o64_valid, q.size() > 0);
            if (q.size() > 0) begin
                e32 = ref_decode(q[0].inst, 32, MEXT);
                e64 = ref_decode(q[0].inst, 64, MEXT);
                chk("pc32", o32_pc, q[0].pc[31:0]);
                chk("opcode32", o32_opcode, e32.opcode);
                chk("funct3_32", o32_funct3, e32.funct3);
                chk("funct7_32", o32_funct7, e32.funct7);
                chk("rs1_32", o32_rs1, e32.rs1);
                chk("rs2_32", o32_rs2, e32.rs2);
                chk("rd32", o32_rd, e32.rd);
                chk("imm32", o32_imm, e32.imm[31:0]);
                chk("itype32", o32_itype, e32.itype);
                chk("illegal32", o32_illegal, e32.illegal);
                chk("pc64", o64_pc, q[0].pc);
                chk("rs1_64", o64_rs1, e64.rs1);
                chk("rs2_64", o64_rs2, e64.rs2);
                chk("rd64", o64_rd, e64.rd);
                chk("imm64", o64_imm, e64.imm);
                chk("itype64", o64_itype, e64.itype);
                chk("illegal64", o64_illegal, e64.illegal);
                chk("funct7_64", o64_funct7, e64.funct7);
                if (out_ready && !flush)
                    $display("xfer pc=%h inst=%h itype32=%0d ill32=%0d itype64=%0d ill64=%0d",
                             q[0].pc, q[0].inst, o32_itype, o32_illegal, o64_itype, o64_illegal);
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    localparam logic [6:0] OPS [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                        7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k < 13) begin
            r[6:0] = OPS[k];
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t p;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;

        // Model pins
        p = ref_decode(32'hFFF00093, 32, 1'b0);
        chk("pin_addi_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_addi_rd", p.rd, 1);
        p = ref_decode(32'hFE208EE3, 32, 1'b0);
        chk("pin_beq_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        p = ref_decode(32'h800002B7, 32, 1'b0);
        chk("pin_lui_imm", p.imm, 64'hFFFF_FFFF_8000_0000);
        p = ref_decode(32'h0010006F, 32, 1'b0);
        chk("pin_jal_imm", p.imm, 64'h800);
        p = ref_decode(32'hFE20AE23, 32, 1'b0);
        chk("pin_sw_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pin_sw_rs2", p.rs2, 2);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o32_valid, 0);
        chk("rst_ready", o32_in_ready, 1);
        chk("rst_itype", o32_itype, 7);
        chk("rst_imm", o32_imm, 0);
        chk("rst_pc", o32_pc, 0);
        chk("rst_illegal", o32_illegal, 0);
        chk("rst_itype64", o64_itype, 7);
        rst_n = 1'b1;
        step();

        // addi x1,x0,-1
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h100; out_ready = 1'b1;
        chk("addi_pre_valid", o32_valid, 0);
        step();
        chk("addi_valid", o32_valid, 1);
        chk("addi_imm", o32_imm, 32'hFFFF_FFFF);
        chk("addi_imm64", o64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", o32_rd, 1);
        chk("addi_rs1", o32_rs1, 0);
        chk("addi_rs2", o32_rs2, 0);
        chk("addi_itype", o32_itype, 1);
        chk("addi_illegal", o32_illegal, 0);

        // beq x1,x2,-4
        in_inst = 32'hFE208EE3; in_pc = 64'h104;
        step();
        chk("beq_imm", o32_imm, 32'hFFFF_FFFC);
        chk("beq_rs1", o32_rs1, 1);
        chk("beq_rs2", o32_rs2, 2);
        chk("beq_rd", o32_rd, 0);
        chk("beq_itype", o32_itype, 3);
        chk("beq_pc", o32_pc, 32'h104);

        // all-zero word
        in_inst = 32'h0000_0000; in_pc = 64'h108;
        step();
        chk("zero_illegal", o32_illegal, 1);
        chk("zero_itype", o32_itype, 7);
        chk("zero_rd", o32_rd, 0);
        chk("zero_imm", o32_imm, 0);

        // slli x1,x1,33: inst[25]=1
        in_inst = 32'h0210_9093; in_pc = 64'h10C;
        step();
        chk("slli33_illegal32", o32_illegal, 1);
        chk("slli33_illegal64", o64_illegal, 0);
        chk("slli33_itype64", o64_itype, 1);
        chk("slli33_imm64", o64_imm, 64'h21);

        // mul x3,x1,x2
        in_inst = 32'h0220_81B3; in_pc = 64'h110;
        step();
        chk("mul_funct7", o32_funct7, 7'h01);
`ifdef DECODE_MEXT_EN
        chk("mul_illegal", o32_illegal, 0);
        chk("mul_itype", o32_itype, 0);
        chk("mul_rd", o32_rd, 3);
`else
        chk("mul_illegal", o32_illegal, 1);
        chk("mul_itype", o32_itype, 7);
`endif
        in_valid = 1'b0;
        step();
        chk("drain_valid", o32_valid, 0);

        // Backpressure: three back-to-back with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h200;
        step();
        chk("bp_ready1", o32_in_ready, 1);
        in_pc = 64'h204;
        step();
        chk("bp_ready2", o32_in_ready, 0);
        chk("bp_head", o32_pc, 32'h200);
        in_pc = 64'h208;
        step();
        chk("bp_stable", o32_pc, 32'h200);
        chk("bp_ready3", o32_in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_second", o32_pc, 32'h204);
        chk("bp_ready_rise", o32_in_ready, 1);
        step();
        chk("bp_third", o32_pc, 32'h208);
        in_valid = 1'b0;
        step();
        chk("bp_empty", o32_valid, 0);

        // Flush with M and S full and an input offered
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h300;
        step();
        in_pc = 64'h304;
        step();
        chk("fl_full", o32_in_ready, 0);
        in_pc = 64'h308; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", o32_valid, 0);
        chk("fl_ready", o32_in_ready, 1);
        step();
        chk("fl_dropped", o32_valid, 0);

        // Flush with only M full while an acceptable input is offered
        in_valid = 1'b1; in_pc = 64'h310;
        step();
        in_pc = 64'h314; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid", o32_valid, 0);
        step();
        chk("fl2_dropped", o32_valid, 0);

        // Asynchronous reset mid-operation
        in_valid = 1'b1; in_pc = 64'h320;
        step();
        in_pc = 64'h324;
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", o32_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", o32_valid, 0);
        chk("ar_ready", o32_in_ready, 1);
        chk("ar_itype", o32_itype, 7);
        chk("ar_valid64", o64_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised traffic
        for (int c = 0; c < 2500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/RV64I instruction-decode pipeline stage. It sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake, splits it into opcode, function, register and immediate fields, classifies the format, flags illegal encodings, and presents the result from an output register. A 2-entry skid buffer means `in_ready` never depends combinationally on `out_ready`.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64. Sets the width of `pc` and the sign-extension width of `imm`.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `flush` input 1: synchronous kill of all buffered instructions.
- `in_valid` input 1: fetch offers an instruction.
- `in_ready` output 1: the stage can accept an instruction.
- `in_inst` input 32: raw instruction word.
- `in_pc` input XLEN: PC of `in_inst`.
- `out_valid` output 1: decoded instruction is present.
- `out_ready` input 1: execute accepts the instruction.
- `out_pc` output XLEN: PC carried through.
- `out_opcode` output 7, `out_funct3` output 3, `out_funct7` output 7: raw fields.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices; forced to 0 when the format does not use the field.
- `out_imm` output XLEN: sign-extended immediate; 0 for R-type.
- `out_itype` output 3: format code, R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- `out_illegal` output 1: the encoding is not supported.

## Operation
- Decode is combinational on `in_inst`. The result is captured into the main register (M) or the skid register (S).
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- `in_ready` = !S.valid.
- `out_valid` = M.valid. All outputs are driven from M.
- Per-cycle update:
  - If the output transfers, or M is empty: M loads S if S is valid, otherwise M loads the input if it transfers, otherwise M clears.
  - If M is full and stalled, an input transfer goes into S.
- Ordering is strict FIFO and no instruction is lost or duplicated.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM. With XLEN=64, OP-IMM-32 and OP-32 are also supported.
- Immediates follow the standard I/S/B/U/J bit scrambles. B and J immediates have bit 0 = 0. U-type is `inst[31:12]<<12`, sign-extended to XLEN.
- `out_illegal` is set for:
  - an unknown opcode;
  - `inst[1:0]` != 2'b11;
  - OP funct7 other than 0x00, or 0x20 with funct3 0/5;
  - shift-immediate upper bits nonzero (the shamt width is 5 or 6 bits per XLEN);
  - BRANCH funct3 2/3;
  - LOAD/STORE funct3 outside the legal set for XLEN.
- An illegal instruction still flows through with `out_itype`=NONE, and its rs/rd/imm fields read 0.
- `flush` clears M.valid and S.valid at the next edge and drops any input offered in the same cycle. `flush` has priority over every transfer.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`. Throughput is 1 per cycle while `out_ready` is held high.
- During reset: `out_valid`=0, all out_* data=0, `out_itype`=NONE, `out_illegal`=0, `in_ready`=1.
- Reset asserted mid-operation empties both registers immediately (asynchronously).
- Outputs stay stable while `out_valid && !out_ready`.
- `in_ready` is a register output with no combinational path from `out_ready`.
- After a stall is released, `in_ready` rises the cycle after S drains.

## Configuration
- `DECODE_MEXT_EN` defined: OP and OP-32 with funct7=0x01 decode as legal R-type (MUL/DIV/REM family).
- Without it, funct7=0x01 raises `out_illegal`.

## Structure
- Package `decode_pkg`:
  - opcode localparams;
  - the `itype` encoding;
  - funct7 constants.
- Sub-module `imm_gen`: combinational; inputs are `inst` and the format code, output is the XLEN immediate. It is used only inside `decode_stage`.

## Test plan
- `addi x1,x0,-1` (0xFFF00093), XLEN=32:
  - `out_imm`=0xFFFFFFFF, `out_rd`=1, `out_rs1`=0, `out_rs2`=0;
  - `out_itype`=I, `out_illegal`=0;
  - `out_valid` rises 1 cycle after acceptance.
- `beq x1,x2,-4` (0xFE208EE3): `out_imm`=0xFFFFFFFC, `out_rs1`=1, `out_rs2`=2, `out_rd`=0, `out_itype`=B.
- Backpressure: hold `out_ready`=0 and offer 3 instructions back-to-back.
  - The 1st is held in M, the 2nd in S, and `in_ready`=0 from cycle 2.
  - After `out_ready`=1, all 3 emerge in order with none lost.
- `flush` while M and S are full and an input is offered: `out_valid`=0 next cycle, `in_ready`=1, and the offered input is dropped.
- Illegal encodings:
  - 0x00000000 gives `out_illegal`=1, `out_itype`=NONE;
  - `slli` with `inst[25]`=1 is illegal at XLEN=32 and legal at XLEN=64.
- `mul x3,x1,x2` (0x022081B3): with `DECODE_MEXT_EN`, legal, `out_funct7`=0x01, `out_itype`=R; without it, `out_illegal`=1.
